shift_arbiter: RTL
==================

# shift_arbiter

Shares one `arithshiftbidir` barrel shifter between two requesters, typically the integer ALU shift path (port 0) and the load/store byte-alignment path (port 1). It round-robins valid/ready requests onto the shifter and synthesizes logical right shifts from the arithmetic shifter by masking. Optionally it sequences a two-pass rotate-right. Results are registered and returned with the winning port's id under valid/ready backpressure.

## Interface
- `WIDTH`, default 32: data width.
- `DISTW`, default 5: distance width; WIDTH = 2**DISTW.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this edge when ready&valid.
- `req0_op`, `req1_op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- `req0_data`, `req1_data`  in  WIDTH  operand.
- `req0_dist`, `req1_dist`  in  DISTW  shift distance.
- `rsp_valid`  out  1  result held.
- `rsp_ready`  in  1  consumer takes result when rsp_valid&rsp_ready.
- `rsp_data`  out  WIDTH  result.
- `rsp_id`  out  1  port that issued the result.

## Operation
- FSM states: IDLE (output register empty), HOLD (result valid), PASS2 (rotate second pass).
- can_accept = (state != PASS2) && (!rsp_valid || rsp_ready). Accept and drain in the same cycle are allowed.
- Arbitration uses a 1-bit round-robin pointer `prio`. If both ports are valid, the port equal to `prio` wins. A lone valid port always wins. After any accept, `prio` is set to the other port.
- reqN_ready = can_accept && grantN. Ready may depend on both valids. A losing requester must hold its request stable.
- SLL: direction 0. SRA: direction 1.
- SRL: direction 1, result ANDed with mask = all-ones >> dist. dist=0 gives the full mask.
- ROTR, dist≠0: pass 1 computes SRL(data, dist) into a partial register and enters PASS2. Pass 2 computes SLL(data, WIDTH−dist). Result = partial | pass2, then HOLD.
- ROTR, dist=0: single pass, result = data.
- PASS2 reuses the captured operand. No requester is granted during PASS2.
- HOLD: rsp_data and rsp_id are stable until drained. On drain with no accept, the next state is IDLE. On drain with an accept, the state stays HOLD (or goes to PASS2) with new contents.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, prio=0, state=IDLE, req*_ready=0 during reset.
- Reset mid-operation: an in-flight rotate or held result is discarded without a response.

## Timing
- Accept at edge N: SLL/SRL/SRA/ROTR(dist=0) give rsp_valid at N+1.
- Accept at edge N: ROTR(dist≠0) gives rsp_valid at N+2.
- Throughput is one single-pass op per cycle with rsp_ready held high. A rotate with dist≠0 occupies two cycles.
- The shifter and mask are combinational between the operand mux and the output register. There is no additional pipeline stage.

## Configuration
- Macro: `SHIFT_ARB_ROTR_EN`.
- Defined: op 11 performs ROTR as above, and PASS2 and the partial register exist.
- Undefined: op 11 is executed as SRL with single-pass latency, and the PASS2 state and partial register are not built.

## Structure
- Shared package `shift_pkg` holds:
  - op encodings `SHIFT_SLL`, `SHIFT_SRL`, `SHIFT_SRA`, `SHIFT_ROTR`;
  - the FSM state typedef;
  - the WIDTH/DISTW defaults.
- Sub-module: a single `arithshiftbidir` instance (lpm_width=WIDTH, lpm_widthdist=DISTW). Operand, distance and direction muxes, mask, arbiter and FSM are local logic.

## Test plan
- SLL: req0 data 0x00000030, dist 4 → at N+1, rsp_data 0x00000300, rsp_id 0.
- SRA/SRL: req1 data 0x80000030, dist 4 → SRA gives 0xF8000003 and SRL gives 0x08000003, both rsp_id 1. With dist 0, SRL returns 0x80000030.
- Contention: both valid every cycle with rsp_ready=1 after reset → grants 0,1,0,1, and rsp_id alternates starting with 0.
- Backpressure: rsp_ready=0 for 3 cycles while HOLD → rsp_data and rsp_id stable, both req*_ready=0. Raising rsp_ready drains and accepts in the same cycle.
- ROTR with macro: 0x12345678, dist 8 → 0x78123456 at N+2, no grant at N+1. With dist 0, returns 0x12345678 at N+1. Without the macro, dist 8 → 0x00123456 at N+1.
- Reset mid-rotate: rst_n=0 during PASS2 → next cycle rsp_valid=0, prio=0, IDLE, and no stale response after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op encodings, FSM state type, size defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_pkg;

  localparam int SHIFT_WIDTH_DEF = 32;
  localparam int SHIFT_DISTW_DEF = 5;

  localparam logic [1:0] SHIFT_SLL  = 2'b00;
  localparam logic [1:0] SHIFT_SRL  = 2'b01;
  localparam logic [1:0] SHIFT_SRA  = 2'b10;
  localparam logic [1:0] SHIFT_ROTR = 2'b11;

  typedef logic [1:0] shift_state_t;

  localparam shift_state_t ST_IDLE  = 2'd0;  // output register empty
  localparam shift_state_t ST_HOLD  = 2'd1;  // result valid, waiting for drain
  localparam shift_state_t ST_PASS2 = 2'd2;  // second pass of a rotate in flight

endpackage

// File: rtl/arithshiftbidir.sv
// Combinational bidirectional barrel shifter: direction 0 = logical left, 1 = arithmetic right.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: data (operand), distance (shift count), direction, result.
module arithshiftbidir #(
  parameter int lpm_width     = 32,
  parameter int lpm_widthdist = 5
) (
  input  logic [lpm_width-1:0]     data,
  input  logic [lpm_widthdist-1:0] distance,
  input  logic                     direction,
  output logic [lpm_width-1:0]     result
);

  logic [lpm_width-1:0] left_res;
  logic [lpm_width-1:0] right_res;

  assign left_res  = data << distance;
  assign right_res = $signed(data) >>> distance;
  assign result    = direction ? right_res : left_res;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one arithmetic barrel shifter between two requesters.
// Latency: accept at edge N -> rsp_valid after N (single pass), after N+1 for a two-pass rotate.
// Backpressure: requests accepted only when the output register is free or draining this edge.
// Ports: clock/rst_n (sync, active-low); req0_*/req1_* valid/ready requests with op, data, dist;
//        rsp_valid/rsp_ready/rsp_data/rsp_id registered result with the issuing port id.
// Build option: SHIFT_ARB_ROTR_EN enables the two-pass rotate-right; without it op 11 acts as SRL.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH_DEF,
  parameter int DISTW = SHIFT_DISTW_DEF
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [DISTW-1:0] req0_dist,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [DISTW-1:0] req1_dist,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
);

  shift_state_t     state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;

  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  logic             sel;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [DISTW-1:0] sel_dist;

  logic             op_right;
  logic             op_mask;
  logic             two_pass;
  logic             in_pass2;
  logic [WIDTH-1:0] pass2_result;

  logic [WIDTH-1:0] sh_data;
  logic [DISTW-1:0] sh_dist;
  logic             sh_dir;
  logic [WIDTH-1:0] sh_result;
  logic [WIDTH-1:0] sh_mask;
  logic [WIDTH-1:0] masked;

  // Gating with rst_n keeps both readies low while reset is asserted.
  assign can_accept = rst_n && (state_q != ST_PASS2) &&
                      ((state_q != ST_HOLD) || rsp_ready);

  // A lone valid always wins; on contention the port matching prio wins.
  assign grant0     = req0_valid && (!req1_valid || !prio_q);
  assign grant1     = req1_valid && (!req0_valid ||  prio_q);
  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;
  assign accept     = req0_ready || req1_ready;
  assign sel        = grant1;

  assign sel_op   = sel ? req1_op   : req0_op;
  assign sel_data = sel ? req1_data : req0_data;
  assign sel_dist = sel ? req1_dist : req0_dist;

  // SRL (and ROTR pass 1, or ROTR itself when rotate support is absent) is an
  // arithmetic right shift with the sign-filled upper bits masked off.
  always_comb begin
    op_right = 1'b0;
    op_mask  = 1'b0;
    case (sel_op)
      SHIFT_SLL:  begin op_right = 1'b0; op_mask = 1'b0; end
      SHIFT_SRL:  begin op_right = 1'b1; op_mask = 1'b1; end
      SHIFT_SRA:  begin op_right = 1'b1; op_mask = 1'b0; end
      SHIFT_ROTR: begin op_right = 1'b1; op_mask = 1'b1; end
      default:    begin op_right = 1'b0; op_mask = 1'b0; end
    endcase
  end

`ifdef SHIFT_ARB_ROTR_EN
  logic [WIDTH-1:0] op_data_q;
  logic [DISTW-1:0] op_dist_q;
  logic [WIDTH-1:0] partial_q;

  assign in_pass2 = (state_q == ST_PASS2);
  assign two_pass = (sel_op == SHIFT_ROTR) && (sel_dist != '0);

  // Pass 2 is a left shift of the captured operand by WIDTH-dist, which in
  // DISTW bits is simply the two's complement of dist (dist is never zero here).
  assign sh_data  = in_pass2 ? op_data_q : sel_data;
  assign sh_dist  = in_pass2 ? ((~op_dist_q) + DISTW'(1)) : sel_dist;
  assign sh_dir   = in_pass2 ? 1'b0 : op_right;
  assign pass2_result = partial_q | sh_result;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      op_data_q <= '0;
      op_dist_q <= '0;
      partial_q <= '0;
    end else if (accept && two_pass) begin
      op_data_q <= sel_data;
      op_dist_q <= sel_dist;
      partial_q <= masked;
    end
  end
`else
  assign in_pass2     = 1'b0;
  assign two_pass     = 1'b0;
  assign sh_data      = sel_data;
  assign sh_dist      = sel_dist;
  assign sh_dir       = op_right;
  assign pass2_result = '0;
`endif

  arithshiftbidir #(
    .lpm_width     (WIDTH),
    .lpm_widthdist (DISTW)
  ) u_shifter (
    .data      (sh_data),
    .distance  (sh_dist),
    .direction (sh_dir),
    .result    (sh_result)
  );

  assign sh_mask = {WIDTH{1'b1}} >> sh_dist;
  assign masked  = (op_mask && !in_pass2) ? (sh_result & sh_mask) : sh_result;

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (in_pass2) begin
      rsp_data_d = pass2_result;
      state_d    = ST_HOLD;
    end else begin
      if ((state_q == ST_HOLD) && rsp_ready) begin
        state_d = ST_IDLE;
      end
      // An accept overrides the drain above: the register is refilled in the same edge.
      if (accept) begin
        prio_d   = ~sel;
        rsp_id_d = sel;
        if (two_pass) begin
          state_d = ST_PASS2;
        end else begin
          rsp_data_d = masked;
          state_d    = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == ST_HOLD);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

endmodule
